// File: rtl/sweep_pkg.sv
// Shared types and MISR helpers for the exhaustive-sweep capture stage.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  localparam int          MISR_W    = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'h0000;

  // One MISR shift: left shift, fold the polynomial on carry-out, inject the response bit.
  function automatic logic [15:0] misr_step(input logic [15:0] cur, input logic din);
    logic [15:0] nxt;
    nxt = {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000) ^ {15'h0000, din};
    return nxt;
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// 16-bit multiple-input signature register compacting the CUT responses.
module sweep_misr
  import sweep_pkg::*;
(
  input  logic        CK,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] sig
);

  // Signature register: cleared to the seed at sweep start, stepped once per hold window.
  always_ff @(posedge CK) begin
    if (reset) begin
      sig <= 16'h0000;
    end else if (clr) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= misr_step(sig, din);
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/sweep_capture.sv
// Drives every CUT input pattern in ascending order and captures the CUT
// response into a truth-table vector and a MISR signature.
module sweep_capture
  import sweep_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int HOLD  = 1,
  parameter int SIG_W = 16
) (
  input  logic                   CK,
  input  logic                   reset,
  input  logic                   start,
  output logic [N_IN-1:0]        pattern,
  output logic                   pattern_valid,
  input  logic                   dut_out,
  output logic [(1<<N_IN)-1:0]   resp_vec,
  output logic [SIG_W-1:0]       sig,
  output logic                   busy,
  output logic                   done
);

  localparam int              NPAT      = 1 << N_IN;
  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] PAT_LAST  = {N_IN{1'b1}};

  sweep_state_t  state;
  sweep_state_t  next_state;
  logic [HW-1:0] hold_cnt;
  logic          accept;
  logic          step;
  logic          last;

  // State register; status outputs are registered from the next state so they line up with it.
  always_ff @(posedge CK) begin
    if (reset) begin
      state         <= IDLE;
      pattern_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= next_state;
      pattern_valid <= (next_state == DRIVE);
      busy          <= (next_state != IDLE);
      done          <= (next_state == DONE);
    end
  end

  // Next-state logic; start is only honoured in IDLE, so requests while busy are dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = DRIVE;
        else       next_state = IDLE;
      end
      DRIVE: begin
        if (last) next_state = DONE;
        else      next_state = DRIVE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control strobes: sweep accept, end of hold window, and end of the final window.
  always_comb begin
    accept = 1'b0;
    step   = 1'b0;
    last   = 1'b0;
    if (state == IDLE) begin
      accept = start;
    end else begin
      accept = 1'b0;
    end
    if ((state == DRIVE) && (hold_cnt == HOLD_LAST)) begin
      step = 1'b1;
    end else begin
      step = 1'b0;
    end
    last = step && (pattern == PAT_LAST);
  end

  // Pattern/hold counters and truth-table capture; pattern parks at all-ones after the sweep.
  always_ff @(posedge CK) begin
    if (reset) begin
      pattern  <= {N_IN{1'b0}};
      hold_cnt <= {HW{1'b0}};
      resp_vec <= {NPAT{1'b0}};
    end else if (accept) begin
      pattern  <= {N_IN{1'b0}};
      hold_cnt <= {HW{1'b0}};
      resp_vec <= {NPAT{1'b0}};
    end else if (step) begin
      resp_vec[pattern] <= dut_out;
      hold_cnt          <= {HW{1'b0}};
      if (last) begin
        pattern <= pattern;
      end else begin
        pattern <= pattern + N_IN'(1);
      end
    end else if (state == DRIVE) begin
      hold_cnt <= hold_cnt + HW'(1);
    end else begin
      hold_cnt <= hold_cnt;
    end
  end

  sweep_misr u_misr (
    .CK    (CK),
    .reset (reset),
    .clr   (accept),
    .en    (step),
    .din   (dut_out),
    .sig   (sig)
  );

endmodule

// File: tb/tb_sweep_capture.sv
// Self-checking bench: table of truth tables swept through a HOLD=1 instance,
// plus hand sequences for restart, abort and a HOLD=3 instance.
module tb_sweep_capture;

  logic        CK;
  logic        reset;
  logic        start0, start1;
  logic [2:0]  pattern0, pattern1;
  logic        pattern_valid0, pattern_valid1;
  logic        dut_out0, dut_out1;
  logic [7:0]  resp_vec0, resp_vec1;
  logic [15:0] sig0, sig1;
  logic        busy0, busy1, done0, done1;
  logic [7:0]  tt_cur;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  tt;
    logic [7:0]  er;
    logic [15:0] es;
  } vec_t;

  typedef struct {
    logic [7:0]  r;
    logic [15:0] s;
  } exp_t;

  vec_t vecs[23];
  exp_t sb_q[$];

  sweep_capture #(.N_IN(3), .HOLD(1), .SIG_W(16)) u0 (
    .CK(CK), .reset(reset), .start(start0), .pattern(pattern0),
    .pattern_valid(pattern_valid0), .dut_out(dut_out0), .resp_vec(resp_vec0),
    .sig(sig0), .busy(busy0), .done(done0)
  );

  sweep_capture #(.N_IN(3), .HOLD(3), .SIG_W(16)) u1 (
    .CK(CK), .reset(reset), .start(start1), .pattern(pattern1),
    .pattern_valid(pattern_valid1), .dut_out(dut_out1), .resp_vec(resp_vec1),
    .sig(sig1), .busy(busy1), .done(done1)
  );

  assign dut_out0 = tt_cur[pattern0];
  assign dut_out1 = &pattern1;

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  function automatic logic [15:0] model_sig(input logic [7:0] resp);
    logic [15:0] s;
    logic        fb;
    s = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      fb = s[15];
      s  = {s[14:0], 1'b0};
      if (fb) s = s ^ 16'h1021;
      s[0] = s[0] ^ resp[k];
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input logic [7:0] r, input logic [15:0] s);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected_done: got done with empty queue at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      chk("resp_vec", {24'h0, r}, {24'h0, e.r});
      chk("sig", {16'h0, s}, {16'h0, e.s});
    end
  endtask

  // One HOLD=1 sweep; start optionally re-pulsed at cycle pulse_cyc while busy.
  task automatic run0(input logic [7:0] er, input logic [15:0] es, input int pulse_cyc);
    exp_t e;
    @(negedge CK);
    start0 = 1'b1;
    e.r = er; e.s = es;
    sb_q.push_back(e);
    for (int c = 1; c <= 11; c++) begin
      @(negedge CK);
      start0 = (c == pulse_cyc);
      chk("busy", {31'h0, busy0}, {31'h0, (c <= 9)});
      chk("done", {31'h0, done0}, {31'h0, (c == 9)});
      chk("pattern_valid", {31'h0, pattern_valid0}, {31'h0, (c <= 8)});
      if (c <= 8) chk("pattern", {29'h0, pattern0}, c - 1);
      else        chk("pattern_hold", {29'h0, pattern0}, 32'd7);
      if (done0) sb_pop(resp_vec0, sig0);
    end
    start0 = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [7:0] xt;
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    tt_cur = 8'h00;

    xt = 8'h00;
    for (int k = 0; k < 8; k++) xt[k] = ^k[2:0];
    vecs[0] = '{tt: xt,    er: 8'h96, es: model_sig(8'h96)};
    vecs[1] = '{tt: 8'hFF, er: 8'hFF, es: 16'h00FF};
    vecs[2] = '{tt: 8'h00, er: 8'h00, es: 16'h0000};
    for (int i = 3; i < 23; i++) begin
      vecs[i].tt = 8'($urandom_range(0, 255));
      vecs[i].er = vecs[i].tt;
      vecs[i].es = model_sig(vecs[i].tt);
    end

    repeat (3) @(negedge CK);
    reset = 1'b0;
    @(negedge CK);
    chk("rst_pattern", {29'h0, pattern0}, 32'd0);
    chk("rst_pattern_valid", {31'h0, pattern_valid0}, 32'd0);
    chk("rst_resp_vec", {24'h0, resp_vec0}, 32'd0);
    chk("rst_sig", {16'h0, sig0}, 32'd0);
    chk("rst_busy", {31'h0, busy0}, 32'd0);
    chk("rst_done", {31'h0, done0}, 32'd0);

    // Table-driven sweeps
    for (int i = 0; i < 23; i++) begin
      tt_cur = vecs[i].tt;
      run0(vecs[i].er, vecs[i].es, 0);
    end

    // start re-pulsed mid-sweep must be ignored
    tt_cur = xt;
    run0(8'h96, model_sig(8'h96), 3);

    // start held high across DONE: back-to-back sweeps, resp_vec cleared at restart
    @(negedge CK);
    start0 = 1'b1;
    e.r = 8'h96; e.s = model_sig(8'h96);
    sb_q.push_back(e);
    for (int c = 1; c <= 21; c++) begin
      @(negedge CK);
      start0 = (c <= 10);
      if (c == 10) sb_q.push_back(e);
      chk("hh_busy", {31'h0, busy0}, {31'h0, (c <= 9) || (c >= 11 && c <= 19)});
      chk("hh_done", {31'h0, done0}, {31'h0, (c == 9) || (c == 19)});
      if (c == 11) chk("hh_resp_clear", {24'h0, resp_vec0}, 32'd0);
      if (done0) sb_pop(resp_vec0, sig0);
    end
    start0 = 1'b0;

    // Reset in cycle 4 aborts the sweep with no done pulse
    @(negedge CK);
    start0 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CK);
      start0 = 1'b0;
      if (c == 4) reset = 1'b1;
    end
    @(negedge CK);
    reset = 1'b0;
    chk("abort_pattern", {29'h0, pattern0}, 32'd0);
    chk("abort_pattern_valid", {31'h0, pattern_valid0}, 32'd0);
    chk("abort_resp_vec", {24'h0, resp_vec0}, 32'd0);
    chk("abort_sig", {16'h0, sig0}, 32'd0);
    chk("abort_busy", {31'h0, busy0}, 32'd0);
    chk("abort_done", {31'h0, done0}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge CK);
      chk("abort_no_done", {31'h0, done0}, 32'd0);
    end
    run0(8'h96, model_sig(8'h96), 0);

    // HOLD=3 instance with an AND CUT
    @(negedge CK);
    start1 = 1'b1;
    e.r = 8'h80; e.s = model_sig(8'h80);
    sb_q.push_back(e);
    for (int c = 1; c <= 27; c++) begin
      @(negedge CK);
      start1 = 1'b0;
      chk("h3_busy", {31'h0, busy1}, {31'h0, (c <= 25)});
      chk("h3_done", {31'h0, done1}, {31'h0, (c == 25)});
      if (c <= 24) chk("h3_pattern", {29'h0, pattern1}, (c - 1) / 3);
      if (done1) sb_pop(resp_vec1, sig1);
    end

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
